// File: rtl/mjolnir_sink.sv
// Result-capture sink for the mjolnir adder: show-ahead FIFO of {cout, s}, sticky carry flag
// and an optional wide running accumulator enabled by the MJOLNIR_SINK_ACC_EN macro.
module mjolnir_sink #(
  parameter int K     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [K-1:0]             s,
  input  logic                     cout,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [K:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     carry_seen,
  output logic [K+7:0]             acc,
  output logic                     acc_wrap
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = K + 8;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid depend only on registered state, so a pop never enables a
  // same-cycle push into a full FIFO and producers may hold data freely while not ready.

  logic [K:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_carry_seen;
  logic          w_push;
  logic          w_pop;

  assign in_ready   = (r_count != CW'(DEPTH));
  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign count      = r_count;
  assign carry_seen = r_carry_seen;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_carry_seen <= 1'b0;
    end else if (clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_carry_seen <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_push && cout) r_carry_seen <= 1'b1;
    end
  end

  // Storage carries no reset; only a valid, non-flushed push writes it.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !clr) r_mem[r_wr_ptr] <= {cout, s};
  end

`ifdef MJOLNIR_SINK_ACC_EN
  logic [AW-1:0] r_acc;
  logic          r_acc_wrap;
  logic [AW:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {{(AW-K){1'b0}}, cout, s};
  assign acc       = r_acc;
  assign acc_wrap  = r_acc_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_acc      <= '0;
      r_acc_wrap <= 1'b0;
    end else if (w_push) begin
      r_acc <= w_acc_sum[AW-1:0];
      if (w_acc_sum[AW]) r_acc_wrap <= 1'b1;
    end
  end
`else
  assign acc      = '0;
  assign acc_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_mjolnir_sink.sv
// Directed bench for mjolnir_sink: reset, single result, back-pressure, wrap under
// simultaneous push/pop, carry/clr, mid-run reset and the accumulator (or its tie-off).
module tb_mjolnir_sink;
  localparam int K     = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [K-1:0]  s;
  logic          cout;
  logic          in_valid;
  logic          in_ready;
  logic [K:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          clr;
  logic [2:0]    count;
  logic          carry_seen;
  logic [K+7:0]  acc;
  logic          acc_wrap;

  int n_vec = 0;
  int n_err = 0;
  logic [K:0] exp_q[$];
  logic [K:0] exp_head;

  always #5 clk = ~clk;

  mjolnir_sink #(.K(K), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s(s), .cout(cout), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .clr(clr),
    .count(count), .carry_seen(carry_seen), .acc(acc), .acc_wrap(acc_wrap)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic c, input logic [K-1:0] v);
    check_eq("push_ready", in_ready, 1);
    cout = c; s = v; in_valid = 1'b1;
    exp_q.push_back({c, v});
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    exp_head = exp_q.pop_front();
    check_eq("pop_valid", out_valid, 1);
    check_eq(tag, out_data, exp_head);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; s = 64'h77; cout = 1'b1; out_ready = 1'b0;
    #1;
    step(); step();
    check_eq("rst_count", count, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_carry", carry_seen, 0);
    check_eq("rst_acc", acc, 0);
    check_eq("rst_acc_wrap", acc_wrap, 0);
    rst = 1'b0; in_valid = 1'b0; cout = 1'b0;
    step();

    // single result
    push_one(1'b0, 64'd2);
    check_eq("single_valid", out_valid, 1);
    check_eq("single_data", out_data, 65'h0_0000000000000002);
    check_eq("single_count", count, 1);
    pop_one("single_pop");
    check_eq("single_count0", count, 0);
    check_eq("single_empty", out_valid, 0);

    // fill and back-pressure
    for (int i = 1; i <= 4; i++) push_one(1'b0, 64'(i));
    check_eq("full_count", count, 4);
    check_eq("full_in_ready", in_ready, 0);
    s = 64'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("full_reject_count", count, 4);
    check_eq("full_head", out_data, 65'd1);
    pop_one("drain_1");
    check_eq("ready_after_pop", in_ready, 1);
    for (int i = 2; i <= 4; i++) pop_one($sformatf("drain_%0d", i));
    check_eq("drain_count", count, 0);

    // simultaneous push/pop crossing the pointer wrap
    push_one(1'b0, 64'd20);
    push_one(1'b0, 64'd21);
    check_eq("sim_count_pre", count, 2);
    for (int i = 0; i < 3; i++) begin
      exp_head = exp_q.pop_front();
      check_eq("sim_head", out_data, exp_head);
      s = 64'(10 + i); cout = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      exp_q.push_back({1'b0, 64'(10 + i)});
      step();
      check_eq("sim_count", count, 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    pop_one("sim_tail_a");
    pop_one("sim_tail_b");
    check_eq("sim_empty", count, 0);

    // carry flag and clr
    push_one(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("carry_seen", carry_seen, 1);
    check_eq("carry_bit", out_data[64], 1);
    clr = 1'b1; in_valid = 1'b1; s = 64'd3; cout = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; cout = 1'b0;
    exp_q.delete();
    check_eq("clr_count", count, 0);
    check_eq("clr_carry", carry_seen, 0);
    check_eq("clr_acc", acc, 0);
    check_eq("clr_out_valid", out_valid, 0);
    step();
    check_eq("clr_push_dropped", count, 0);

    // reset mid-operation loses buffered entries
    push_one(1'b0, 64'd7);
    push_one(1'b1, 64'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check_eq("midrst_count", count, 0);
    check_eq("midrst_carry", carry_seen, 0);

    // accumulator: streaming pushes of {1, all-ones}
    cout = 1'b1; s = '1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 128; i++) step();
`ifdef MJOLNIR_SINK_ACC_EN
    check_eq("acc_128", acc, 72'hFF_FFFF_FFFF_FFFF_FF80);
    check_eq("acc_wrap_128", acc_wrap, 0);
`else
    check_eq("acc_off_128", acc, 0);
    check_eq("acc_wrap_off_128", acc_wrap, 0);
`endif
    step();
`ifdef MJOLNIR_SINK_ACC_EN
    check_eq("acc_129", acc, 72'h01_FFFF_FFFF_FFFF_FF7F);
    check_eq("acc_wrap_129", acc_wrap, 1);
`else
    check_eq("acc_off_129", acc, 0);
    check_eq("acc_wrap_off_129", acc_wrap, 0);
`endif
    for (int i = 0; i < 127; i++) step();
`ifdef MJOLNIR_SINK_ACC_EN
    check_eq("acc_256", acc, 72'hFF_FFFF_FFFF_FFFF_FF00);
    check_eq("acc_wrap_256", acc_wrap, 1);
`else
    check_eq("acc_off_256", acc, 0);
`endif
    check_eq("stream_count", count, 1);
    check_eq("stream_carry", carry_seen, 1);
    check_eq("stream_head", out_data, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check_eq("stream_drained", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
